// File: rtl/tc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tc_bus_pkg
//  Description : Shared state encoding and owner-index width for tc_bus_arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
package tc_bus_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    function automatic int ow_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : tc_rr_picker
//  Description : Combinational round-robin pick: first requester after `last`
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int OW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OW-1:0]      last_i,
    output logic [OW-1:0]      pick_o,
    output logic               any_req_o
);

    logic [NUM_REQ-1:0] w_rot;
    int                 w_off;
    int                 w_idx;

    // Rotate so bit 0 is the index just after `last`, priority-encode, rotate back.
    always_comb begin
        w_rot = NUM_REQ'({req_i, req_i} >> (int'(last_i) + 1));
        w_off = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = j;
        end
        w_idx = int'(last_i) + 1 + w_off;
        if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
        pick_o    = OW'(w_idx);
        any_req_o = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/tc_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tc_bus_arbiter
//  Description : Round-robin tristate-bus arbiter with bounded tenure and gap
//  Revision    : 1.0 - initial release
// ============================================================================
module tc_bus_arbiter
    import tc_bus_pkg::*;
#(
    parameter int    UUID       = 0,
    parameter string NAME       = "",
    parameter int    NUM_REQ    = 4,
    parameter int    MAX_TENURE = 8,
    parameter int    TURNAROUND = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    output logic [NUM_REQ-1:0]              en,
    output logic [ow_width(NUM_REQ)-1:0]    owner,
    output logic                            busy
);

    localparam int         OW          = ow_width(NUM_REQ);
    localparam logic [7:0] c_TEN_SAT   = (MAX_TENURE == 0) ? 8'd255 : 8'(MAX_TENURE);
    localparam logic [3:0] c_TURN_LOAD = 4'(TURNAROUND);

    logic [1:0]         state_q,  state_d;
    logic [NUM_REQ-1:0] en_q,     en_d;
    logic [OW-1:0]      owner_q,  owner_d;
    logic [OW-1:0]      last_q,   last_d;
    logic [7:0]         tenure_q, tenure_d;
    logic [3:0]         turn_q,   turn_d;
    logic               busy_q,   busy_d;

    logic [OW-1:0]      w_pick;
    logic               w_any_req;
    logic               w_others;
    logic               w_release;
    logic               w_grant;
    logic               w_unused_ids;

    assign w_unused_ids = (UUID != 0) | (NAME != "");

    tc_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_picker (
        .req_i     (req),
        .last_i    (last_q),
        .pick_o    (w_pick),
        .any_req_o (w_any_req)
    );

    assign w_others  = |(req & ~en_q);
    assign w_release = !req[owner_q] ||
                       ((MAX_TENURE != 0) && (tenure_q == c_TEN_SAT) && w_others);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tenure_d = tenure_q;
        turn_d   = turn_q;
        w_grant  = 1'b0;

        case (state_q)
            ST_IDLE: w_grant = w_any_req;
            ST_GRANT: begin
                if (w_release) begin
                    en_d    = '0;
                    turn_d  = c_TURN_LOAD;
                    state_d = ST_TURN;
                end else if (tenure_q != c_TEN_SAT) begin
                    tenure_d = tenure_q + 8'd1;
                end
            end
            ST_TURN: begin
                if (turn_q > 4'd1) begin
                    turn_d = turn_q - 4'd1;
                end else begin
                    w_grant = w_any_req;
                    turn_d  = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                en_d    = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (w_grant) begin
            en_d         = '0;
            en_d[w_pick] = 1'b1;
            owner_d      = w_pick;
            last_d       = w_pick;
            tenure_d     = 8'd1;
            state_d      = ST_GRANT;
        end

        busy_d = |en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            en_q     <= '0;
            owner_q  <= '0;
            last_q   <= OW'(NUM_REQ - 1);
            tenure_q <= 8'd0;
            turn_q   <= 4'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            tenure_q <= tenure_d;
            turn_q   <= turn_d;
            busy_q   <= busy_d;
        end
    end

    assign en    = en_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    a_owner_range: assert property (@(posedge clk) disable iff (rst) int'(owner_q) < NUM_REQ);
    a_en_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(en_q));

endmodule
`default_nettype wire
